serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial unsigned subtractor. One start request computes a - b, LSB first,
// one bit per clock through a single full-subtractor cell, and then presents
// the result with a one-cycle done pulse.
//
// Operation timeline (start accepted on the rising edge that ends cycle N):
//   cycle N+1 .. N+WIDTH   : SHIFT, one bit per cycle
//   cycle N+WIDTH+1        : DONE, done=1, diff/borrow valid
//   following cycle        : back in IDLE, ready for a new start
//
// Parameters
//   WIDTH   operand/result width in bits (2..32), default 8
//
// Ports
//   clk     in   single clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request one subtraction (accepted only in IDLE)
//   a       in   minuend, sampled when start is accepted
//   b       in   subtrahend, sampled when start is accepted
//   busy    out  high in SHIFT and DONE
//   done    out  one-cycle pulse, diff/borrow valid
//   diff    out  result register, held until the next done pulse
//   borrow  out  final borrow-out (1 = a < b)
//
// Build option
//   SERIAL_SUB_SAT_EN  when defined, diff is forced to zero on completion
//                      whenever the final borrow is 1 (borrow still reports 1).
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             d_bit;
    logic             bo_bit;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_SAT_EN
    // Underflow clamps the result to zero.
    function automatic logic [WIDTH-1:0] sat_underflow(
        input logic [WIDTH-1:0] r,
        input logic             under
    );
        return under ? '0 : r;
    endfunction
`endif

    // Full-subtractor cell on the current LSBs plus the running borrow.
    always_comb begin
        d_bit    = a_sr[0] ^ b_sr[0] ^ br;
        bo_bit   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_next = {d_bit, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // Result fills from the MSB end, so after WIDTH shifts the
                    // first (LSB) difference bit has reached bit 0.
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= bo_bit;
                    if (cnt == CNT_LAST) begin
                        // Outputs load from the final-cycle values so they are
                        // valid in the DONE cycle itself.
`ifdef SERIAL_SUB_SAT_EN
                        diff   <= sat_underflow(res_next, bo_bit);
`else
                        diff   <= res_next;
`endif
                        borrow <= bo_bit;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int errors = 0;
    int checks = 0;

    // Reference state of the result outputs (what they must hold between ops)
    logic [7:0] held8_d;
    logic       held8_b;
    logic [3:0] held4_d;
    logic       held4_b;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    // Behavioural model: unsigned subtraction with optional underflow clamp.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
        int unsigned r;
        logic        u;
        u = (x < y);
        r = (int'(x) - int'(y) + 256) % 256;
`ifdef SERIAL_SUB_SAT_EN
        if (u) r = 0;
`endif
        return {u, 8'(r)};
    endfunction

    function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y);
        int unsigned r;
        logic        u;
        u = (x < y);
        r = (int'(x) - int'(y) + 16) % 16;
`ifdef SERIAL_SUB_SAT_EN
        if (u) r = 0;
`endif
        return {u, 4'(r)};
    endfunction

    // One WIDTH=8 operation, called at a negedge with the DUT idle.
    // inj: cycle offset (1..8) at which a stray start is pulsed, 0 = none.
    // inj_done: also pulse start during the DONE cycle.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       input int inj, input bit inj_done);
        logic [8:0] exp;
        exp = model8(av, bv);
        start8 = 1'b1; a8 = av; b8 = bv;
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= 9; c++) begin
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            checks++;
            if (busy8 !== 1'b1) begin
                errors++; $display("FAIL op8_busy c=%0d got=%b want=1", c, busy8);
            end
            if (c <= 8) begin
                checks++;
                if (done8 !== 1'b0 || diff8 !== held8_d || borrow8 !== held8_b) begin
                    errors++;
                    $display("FAIL op8_shift_hold c=%0d got done=%b diff=%h br=%b want done=0 diff=%h br=%b",
                             c, done8, diff8, borrow8, held8_d, held8_b);
                end
            end else begin
                checks++;
                if (done8 !== 1'b1 || diff8 !== exp[7:0] || borrow8 !== exp[8]) begin
                    errors++;
                    $display("FAIL op8_result a=%0d b=%0d got done=%b diff=%h br=%b want done=1 diff=%h br=%b",
                             av, bv, done8, diff8, borrow8, exp[7:0], exp[8]);
                end
            end
            if (c == inj || (inj_done && c == 9)) begin
                start8 = 1'b1; a8 = 8'd7; b8 = 8'd3;
            end
            @(posedge clk); @(negedge clk);
        end
        start8 = 1'b0;
        held8_d = exp[7:0];
        held8_b = exp[8];
        // Back in IDLE; nothing further may happen on its own.
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== held8_d || borrow8 !== held8_b) begin
                errors++;
                $display("FAIL op8_idle c=%0d got busy=%b done=%b diff=%h br=%b want busy=0 done=0 diff=%h br=%b",
                         c, busy8, done8, diff8, borrow8, held8_d, held8_b);
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv);
        logic [4:0] exp;
        exp = model4(av, bv);
        start4 = 1'b1; a4 = av; b4 = bv;
        @(posedge clk); @(negedge clk);
        start4 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            checks++;
            if (c <= 4) begin
                if (busy4 !== 1'b1 || done4 !== 1'b0 || diff4 !== held4_d || borrow4 !== held4_b) begin
                    errors++;
                    $display("FAIL op4_shift c=%0d got busy=%b done=%b diff=%h br=%b want busy=1 done=0 diff=%h br=%b",
                             c, busy4, done4, diff4, borrow4, held4_d, held4_b);
                end
            end else begin
                if (busy4 !== 1'b1 || done4 !== 1'b1 || diff4 !== exp[3:0] || borrow4 !== exp[4]) begin
                    errors++;
                    $display("FAIL op4_result a=%0d b=%0d got busy=%b done=%b diff=%h br=%b want busy=1 done=1 diff=%h br=%b",
                             av, bv, busy4, done4, diff4, borrow4, exp[3:0], exp[4]);
                end
            end
            @(posedge clk); @(negedge clk);
        end
        held4_d = exp[3:0];
        held4_b = exp[4];
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== held4_d) begin
            errors++;
            $display("FAIL op4_idle got busy=%b done=%b diff=%h want busy=0 done=0 diff=%h",
                     busy4, done4, diff4, held4_d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        held8_d = '0; held8_b = 1'b0;
        held4_d = '0; held4_b = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b diff=%h br=%b want all 0", busy8, done8, diff8, borrow8);
        end
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 4'h0 || borrow4 !== 1'b0) begin
            errors++;
            $display("FAIL reset4 got busy=%b done=%b diff=%h br=%b want all 0", busy4, done4, diff4, borrow4);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start on the very first edge after release, then the basic case.
    task automatic test_basic();
        op8(8'd100, 8'd58, 0, 1'b0);
        op8(8'd5, 8'd9, 0, 1'b0);
    endtask

    task automatic test_boundaries();
        op8(8'd0, 8'd0, 0, 1'b0);
        op8(8'd255, 8'd255, 0, 1'b0);
        op8(8'd0, 8'd255, 0, 1'b0);
        op8(8'd255, 8'd0, 0, 1'b0);
    endtask

    task automatic test_ignore_start();
        op8(8'd100, 8'd58, 3, 1'b1);
        op8(8'd17, 8'd200, 8, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd58;
        @(posedge clk); @(negedge clk);
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_now got busy=%b done=%b diff=%h br=%b want all 0", busy8, done8, diff8, borrow8);
        end
        held8_d = '0; held8_b = 1'b0;
        held4_d = '0; held4_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
                errors++;
                $display("FAIL midreset_after c=%0d got busy=%b done=%b diff=%h br=%b want all 0",
                         c, busy8, done8, diff8, borrow8);
            end
        end
        op8(8'd200, 8'd13, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 9)), 1'($urandom));
    endtask

    task automatic test_width4();
        op4(4'h3, 4'h5);
        op4(4'hF, 4'h1);
        for (int i = 0; i < 8; i++)
            op4(4'($urandom), 4'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_reset_mid_op();
        test_random();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule
